cp0_exc_handler: RTL and testbench
==================================

Name: cp0_exc_handler

Overview:
- Coprocessor-0 exception receiver. It consumes the 5-bit ExcCode that the pipeline stages encode and carry to the macro-PC point, together with external hardware interrupt lines.
- It decides whether to take an exception or interrupt, records SR/Cause/EPC, raises a flush/redirect request, and services mfc0/mtc0/eret.
- It sits beside the M stage and is the consuming end of the per-stage ExcCode coders.

Parameters:
- PRID, 32'h0000_0701, constant value returned on reads of register 15 (PRId).
- HANDLER_PC, 32'h0000_4180, exception entry address driven on handler_pc.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- vpc  input  32  PC of the instruction at the macro-PC point.
- bd_in  input  1  that instruction is in a branch delay slot.
- exc_code_in  input  5  merged ExcCode from the pipeline; 0 means no exception.
- hw_int  input  6  external interrupt lines HW[5:0].
- we  input  1  mtc0 write strobe.
- addr  input  5  CP0 register number for both read and write.
- wdata  input  32  mtc0 data.
- eret  input  1  eret at the macro-PC point.
- rdata  output  32  mfc0 read data.
- req  output  1  take exception/interrupt this cycle; used as flush and redirect.
- handler_pc  output  32  always HANDLER_PC.
- epc_out  output  32  current EPC, used as the eret target.

Behaviour:
- Registers and reset:
  - SR(12): IM at [15:10], EXL at [1], IE at [0]; all other bits read 0.
  - Cause(13): BD at [31], IP at [15:10], ExcCode at [6:2]; all other bits read 0.
  - EPC(14): 32 bits.
  - Async reset (reset==0) clears SR, Cause and EPC to 0 immediately. Hence rdata for 12/13/14 reads 0, req=0, epc_out=0.
- Request logic (combinational, same cycle):
  - int_req = IE & ~EXL & |(hw_int & IM).
  - exc_req = ~EXL & (exc_code_in != 0).
  - req = int_req | exc_req.
- Priority: an interrupt beats an exception when both are pending.
- On a clock edge with req=1, all of the following update at once:
  - EXL<=1.
  - Cause.ExcCode <= int_req ? 0 : exc_code_in.
  - Cause.BD <= bd_in.
  - EPC <= bd_in ? {vpc[31:2],2'b00}-4 : {vpc[31:2],2'b00}.
- EPC word alignment: a misaligned vpc (e.g. from an AdEL fetch fault) is recorded aligned.
- Cause.IP <= hw_int on every edge, independent of req or EXL.
- mtc0 (we=1, req=0):
  - addr 12 writes IM, EXL and IE from wdata.
  - addr 14 writes EPC <= {wdata[31:2],2'b00}.
  - Writes to any other address are ignored; Cause is not software-writable.
- Write with req=1: the write is discarded and req's updates win.
- eret=1 with req=0: EXL<=0 on the edge. eret while EXL=0 has no effect.
- When req=1, eret and we are both ignored.
- While EXL=1 both request terms are 0, so nested exceptions and interrupts are blocked until eret or an mtc0 clears EXL.
- rdata (combinational):
  - addr 12 returns SR, 13 returns Cause, 14 returns EPC, 15 returns PRID, any other address returns 0.
  - Reads return pre-edge values; there is no write-to-read bypass.
- epc_out = EPC register, with no forwarding of the same-cycle mtc0 value.
- Reset asserted mid-handler clears EXL and all registers at once; req falls the same cycle.
- Latency: req is zero-cycle (combinational from inputs). Register effects are visible one edge later.

Test Plan:
1. Reset, then read regs 12, 13, 14 and 15 -> 0, 0, 0, 32'h0000_0701; req=0; handler_pc=32'h0000_4180.
2. exc_code_in=4, vpc=32'h0000_3001, bd_in=0 -> req=1 that cycle. After the edge: EPC=32'h0000_3000, Cause[6:2]=4, SR[1]=1, and req=0 while exc_code_in is held.
3. bd_in=1, vpc=32'h0000_3008, exc_code_in=10 -> EPC=32'h0000_3004, Cause[31]=1, Cause[6:2]=10.
4. mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1), hw_int=6'b000001 -> req=1, then Cause[6:2]=0 and Cause[10]=1. Repeat with IM=0 -> req=0 while Cause[10] still tracks hw_int.
5. With EXL=1, assert eret -> SR[1]=0 next cycle and epc_out holds. Then mtc0 EPC=32'h0000_3103 -> EPC=32'h0000_3100.
6. In the same cycle assert exc_code_in=12 and mtc0 EPC=32'h1234 -> EPC=vpc-aligned, not 32'h1234. Then pulse reset low mid-cycle while EXL=1 -> SR=0 and req=0 immediately.

Source files
------------

// File: rtl/cp0_exc_handler_if.sv
// -----------------------------------------------------------------------------
// cp0_exc_handler_if
// Bundle of signals between the pipeline (macro-PC point / M stage) and the
// coprocessor-0 exception receiver.
//
// Signals:
//   vpc         PC of the instruction at the macro-PC point
//   bd_in       that instruction sits in a branch delay slot
//   exc_code_in merged 5-bit ExcCode from the pipeline coders (0 = none)
//   hw_int      external hardware interrupt lines HW[5:0]
//   we          mtc0 write strobe
//   addr        CP0 register number, shared by mfc0 and mtc0
//   wdata       mtc0 write data
//   eret        eret at the macro-PC point
//   rdata       mfc0 read data
//   req         take exception/interrupt this cycle (flush + redirect)
//   handler_pc  exception entry address
//   epc_out     current EPC, used as the eret target
//
// Modports:
//   master  pipeline side (drives requests, consumes results)
//   slave   CP0 side
// -----------------------------------------------------------------------------
interface cp0_exc_handler_if;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        eret;
  logic [31:0] rdata;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  modport master (
    output vpc,
    output bd_in,
    output exc_code_in,
    output hw_int,
    output we,
    output addr,
    output wdata,
    output eret,
    input  rdata,
    input  req,
    input  handler_pc,
    input  epc_out
  );

  modport slave (
    input  vpc,
    input  bd_in,
    input  exc_code_in,
    input  hw_int,
    input  we,
    input  addr,
    input  wdata,
    input  eret,
    output rdata,
    output req,
    output handler_pc,
    output epc_out
  );
endinterface

// File: rtl/cp0_exc_handler.sv
// -----------------------------------------------------------------------------
// cp0_exc_handler
// Coprocessor-0 exception receiver sitting beside the M stage. It consumes the
// merged ExcCode and the hardware interrupt lines, decides whether to take an
// exception or interrupt, records SR/Cause/EPC, raises the flush/redirect
// request and services mfc0 / mtc0 / eret.
//
// Ports:
//   clk    system clock, state updates on the rising edge
//   reset  asynchronous, active-low reset
//   bus    cp0_exc_handler_if.slave (see interface header for signal list)
//
// Parameters:
//   PRID        value returned on reads of register 15
//   HANDLER_PC  exception entry address driven on handler_pc
// -----------------------------------------------------------------------------
module cp0_exc_handler #(
  parameter logic [31:0] PRID       = 32'h0000_0701,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  cp0_exc_handler_if.slave  bus
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im_q,  im_d;
  logic        exl_q, exl_d;
  logic        ie_q,  ie_d;
  // Cause fields
  logic        bd_q,  bd_d;
  logic [5:0]  ip_q,  ip_d;
  logic [4:0]  exc_q, exc_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [31:0] vpc_aligned;
  logic [31:0] epc_capture;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic        unused_vpc_lsbs;

  // The low PC bits are dropped on capture; a misaligned fetch PC is still
  // recorded word aligned.
  assign unused_vpc_lsbs = ^bus.vpc[1:0];

  // Request logic. EXL masks both terms so nothing nests inside a handler.
  assign int_req = ie_q & ~exl_q & (|(bus.hw_int & im_q));
  assign exc_req = ~exl_q & (bus.exc_code_in != 5'd0);
  assign req     = int_req | exc_req;

  // A delay-slot instruction restarts at its branch, one word earlier.
  assign vpc_aligned = {bus.vpc[31:2], 2'b00};
  assign epc_capture = bus.bd_in ? (vpc_aligned - 32'd4) : vpc_aligned;

  assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
  assign cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};

  // Next-state: a taken request overrides any mtc0 or eret in the same cycle.
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    // Pending-interrupt bits simply sample the lines every cycle.
    ip_d  = bus.hw_int;

    if (req) begin
      exl_d = 1'b1;
      // Interrupts take priority and report ExcCode 0.
      exc_d = int_req ? 5'd0 : bus.exc_code_in;
      bd_d  = bus.bd_in;
      epc_d = epc_capture;
    end else begin
      if (bus.we) begin
        unique case (bus.addr)
          ADDR_SR: begin
            im_d  = bus.wdata[15:10];
            exl_d = bus.wdata[1];
            ie_d  = bus.wdata[0];
          end
          ADDR_EPC: begin
            epc_d = {bus.wdata[31:2], 2'b00};
          end
          default: begin
            // Cause and all other registers are not software writable.
          end
        endcase
      end
      if (bus.eret && exl_q) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q  <= 6'd0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= 6'd0;
      exc_q <= 5'd0;
      epc_q <= 32'd0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  // mfc0 read mux: pre-edge register values, no write bypass.
  always_comb begin
    bus.rdata = 32'd0;
    unique case (bus.addr)
      ADDR_SR:    bus.rdata = sr_val;
      ADDR_CAUSE: bus.rdata = cause_val;
      ADDR_EPC:   bus.rdata = epc_q;
      ADDR_PRID:  bus.rdata = PRID;
      default:    bus.rdata = 32'd0;
    endcase
  end

  assign bus.req        = req;
  assign bus.handler_pc = HANDLER_PC;
  assign bus.epc_out    = epc_q;

endmodule

// File: tb/tb_cp0_exc_handler.sv
// -----------------------------------------------------------------------------
// tb_cp0_exc_handler
// Directed bench for cp0_exc_handler. Inputs change 1 time unit after the
// rising edge; combinational outputs are sampled shortly afterwards.
// -----------------------------------------------------------------------------
module tb_cp0_exc_handler;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  cp0_exc_handler_if bus ();

  cp0_exc_handler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(tag, bus.rdata, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.vpc = 32'd0;
    bus.bd_in = 1'b0;
    bus.exc_code_in = 5'd0;
    bus.hw_int = 6'd0;
    bus.we = 1'b0;
    bus.addr = 5'd0;
    bus.wdata = 32'd0;
    bus.eret = 1'b0;
    #3 reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Reset state
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("rst_prid", 5'd15, 32'h0000_0701);
    rd("rst_other", 5'd3, 32'h0);
    chk("rst_req", {31'd0, bus.req}, 32'd0);
    chk("rst_handler_pc", bus.handler_pc, 32'h0000_4180);
    chk("rst_epc_out", bus.epc_out, 32'h0);

    // Exception, misaligned PC, not in delay slot
    bus.vpc = 32'h0000_3001;
    bus.bd_in = 1'b0;
    bus.exc_code_in = 5'd4;
    #1;
    chk("exc4_req", {31'd0, bus.req}, 32'd1);
    tick();
    chk("exc4_req_blocked", {31'd0, bus.req}, 32'd0);
    rd("exc4_epc", 5'd14, 32'h0000_3000);
    rd("exc4_cause", 5'd13, 32'h0000_0010);
    rd("exc4_sr", 5'd12, 32'h0000_0002);
    chk("exc4_epc_out", bus.epc_out, 32'h0000_3000);

    // eret clears EXL, EPC unchanged
    bus.exc_code_in = 5'd0;
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    rd("eret1_sr", 5'd12, 32'h0);
    chk("eret1_epc_out", bus.epc_out, 32'h0000_3000);

    // Exception in delay slot
    bus.vpc = 32'h0000_3008;
    bus.bd_in = 1'b1;
    bus.exc_code_in = 5'd10;
    #1;
    chk("exc10_req", {31'd0, bus.req}, 32'd1);
    tick();
    bus.exc_code_in = 5'd0;
    bus.bd_in = 1'b0;
    rd("exc10_epc", 5'd14, 32'h0000_3004);
    rd("exc10_cause", 5'd13, 32'h8000_0028);
    rd("exc10_sr", 5'd12, 32'h0000_0002);

    // eret with EXL=1, then mtc0 EPC with no read bypass
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    rd("eret2_sr", 5'd12, 32'h0);
    chk("eret2_epc_out", bus.epc_out, 32'h0000_3004);
    bus.we = 1'b1;
    bus.wdata = 32'h0000_3103;
    rd("mtc0_epc_prewrite", 5'd14, 32'h0000_3004);
    chk("mtc0_epc_out_prewrite", bus.epc_out, 32'h0000_3004);
    tick();
    bus.we = 1'b0;
    rd("mtc0_epc", 5'd14, 32'h0000_3100);

    // mtc0 SR: IM[0]=1, IE=1, then an interrupt
    bus.we = 1'b1;
    bus.addr = 5'd12;
    bus.wdata = 32'h0000_0401;
    tick();
    bus.we = 1'b0;
    rd("mtc0_sr", 5'd12, 32'h0000_0401);
    chk("int_idle_req", {31'd0, bus.req}, 32'd0);
    bus.hw_int = 6'b000001;
    bus.vpc = 32'h0000_5000;
    #1;
    chk("int_req", {31'd0, bus.req}, 32'd1);
    tick();
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr", 5'd12, 32'h0000_0403);
    rd("int_epc", 5'd14, 32'h0000_5000);
    chk("int_req_blocked", {31'd0, bus.req}, 32'd0);

    // eret, then interrupt and exception together: interrupt wins
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    bus.exc_code_in = 5'd4;
    bus.vpc = 32'h0000_6000;
    #1;
    chk("prio_req", {31'd0, bus.req}, 32'd1);
    tick();
    bus.exc_code_in = 5'd0;
    rd("prio_cause", 5'd13, 32'h0000_0400);
    rd("prio_epc", 5'd14, 32'h0000_6000);

    // mtc0 SR with IM=0: EXL cleared, interrupt masked, IP still tracks
    bus.we = 1'b1;
    bus.addr = 5'd12;
    bus.wdata = 32'h0000_0001;
    tick();
    bus.we = 1'b0;
    rd("mask_sr", 5'd12, 32'h0000_0001);
    chk("mask_req", {31'd0, bus.req}, 32'd0);
    rd("mask_cause_ip", 5'd13, 32'h0000_0400);
    bus.hw_int = 6'd0;
    tick();
    rd("ip_track_cause", 5'd13, 32'h0);

    // Cause is not software writable
    bus.we = 1'b1;
    bus.addr = 5'd13;
    bus.wdata = 32'hFFFF_FFFF;
    tick();
    bus.we = 1'b0;
    rd("cause_nowrite", 5'd13, 32'h0);

    // Exception and mtc0 EPC in the same cycle: exception wins
    bus.exc_code_in = 5'd12;
    bus.vpc = 32'h0000_7002;
    bus.bd_in = 1'b0;
    bus.we = 1'b1;
    bus.addr = 5'd14;
    bus.wdata = 32'h0000_1234;
    #1;
    chk("collide_req", {31'd0, bus.req}, 32'd1);
    tick();
    bus.we = 1'b0;
    bus.exc_code_in = 5'd0;
    rd("collide_epc", 5'd14, 32'h0000_7000);
    rd("collide_cause", 5'd13, 32'h0000_0030);
    rd("collide_sr", 5'd12, 32'h0000_0003);

    // Async reset mid-cycle while EXL=1
    bus.hw_int = 6'b000001;
    #1 reset = 1'b0;
    #1;
    rd("midrst_sr", 5'd12, 32'h0);
    rd("midrst_cause", 5'd13, 32'h0);
    chk("midrst_req", {31'd0, bus.req}, 32'd0);
    chk("midrst_epc_out", bus.epc_out, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    rd("postrst_cause_ip", 5'd13, 32'h0000_0400);
    chk("postrst_req", {31'd0, bus.req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
